pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//  Parametrised fetch-address generator for the 3-stage RV32I pipeline.
//  Holds the architectural fetch PC and selects the next PC from reset vector, trap entry,
//  MRET return (epc), taken branch/jump, or sequential increment.
//  Adds a WFI sleep FSM, misaligned-target detection and a one-cycle flush pulse for the
//  decode/execute stages. Sits between the fetch stage and instruction memory.
// PARAMETERS
//  XLEN      32   address width
//  RESET_VEC 0    PC value loaded by reset (XLEN bits)
//  IALIGN    4    sequential increment and required target alignment in bytes (4 only for RV32I)
//  CNT_W     32   perf counter width (used only with PC_PERF_EN)
// PORTS
//  clk           in   1       clock, all state updates on posedge
//  reset         in   1       synchronous, active-high
//  stall         in   1       hazard stall: hold PC, ignore br_taken
//  trap_req      in   1       take trap this cycle (from CSR unit)
//  trap_vec      in   XLEN    trap target (mtvec incl. vectored offset)
//  mret_req      in   1       return from trap
//  epc           in   XLEN    MRET target
//  br_taken      in   1       branch/JAL/JALR redirect request
//  br_target     in   XLEN    redirect target from ALU
//  wfi_req       in   1       WFI instruction in execute
//  wake          in   1       interrupt pending (wakes without trapping)
//  pc            out  XLEN    current fetch address
//  fetch_en      out  1       instruction-memory read enable
//  flush         out  1       PC was redirected last edge; squash younger stages
//  misalign_exc  out  1       one-cycle pulse: br_target misaligned
//  bad_addr      out  XLEN    offending target of last misalign_exc (mtval source)
//  sleeping      out  1       FSM in SLEEP
//  redirect_cnt  out  CNT_W   [PC_PERF_EN only] count of taken redirects
//  stall_cnt     out  CNT_W   [PC_PERF_EN only] count of stalled RUN cycles
// BEHAVIOUR
//  Reset: pc=RESET_VEC, state=RUN, fetch_en=1, flush=0, misalign_exc=0, bad_addr=0,
//    sleeping=0, counters=0. Reset wins over every other input.
//  Next-PC priority in RUN, highest first:
//    1 trap_req  -> pc<=trap_vec with low log2(IALIGN) bits forced 0; flush<=1
//    2 mret_req  -> pc<=epc with low bits forced 0; flush<=1
//    3 stall     -> pc held; br_taken ignored (execute re-presents it after stall)
//    4 br_taken, br_target aligned   -> pc<=br_target; flush<=1
//    5 br_taken, br_target misaligned -> pc held; misalign_exc<=1; bad_addr<=br_target;
//      flush<=0 (CSR unit answers with trap_req)
//    6 wfi_req   -> state<=SLEEP; pc<=pc+IALIGN; fetch_en<=0
//    7 else      -> pc<=pc+IALIGN (wraps modulo 2^XLEN, no flag)
//  trap_req and mret_req override stall; a redirect is never lost.
//  trap_req and mret_req together: trap wins.
//  flush and misalign_exc are registered: high exactly one cycle after the causing edge,
//    never both high together.
//  SLEEP state: pc held, fetch_en=0, sleeping=1; stall, br_taken, wfi_req ignored.
//    trap_req -> RUN, pc<=trap_vec, fetch_en<=1, flush<=1
//    wake (no trap_req) -> RUN, pc held (already next instr), fetch_en<=1, flush<=0
//    mret_req in SLEEP: ignored
//  Latency: redirect target appears on pc the cycle after the request; no bubbles beyond
//    the flush cycle.
//  fetch_en=1 in RUN (including stalled cycles); 0 only in SLEEP.
// CONFIGURATION
//  PC_PERF_EN defined:
//    redirect_cnt +1 on each edge loading trap/mret/branch target.
//    stall_cnt +1 on each RUN edge with stall=1 and no trap/mret.
//    Both saturate at all-ones and clear on reset.
//  Undefined: counters and ports absent; behaviour otherwise identical.
// TESTING
//  T1 reset 3 cycles, RESET_VEC=0x100, release -> pc 0x100,0x104,0x108; flush=0
//  T2 at pc=0x10, br_taken=1 with br_target=0x40 -> pc=0x40 next cycle; flush=1 one cycle;
//     same request with stall=1 -> pc stays 0x10
//  T3 br_target=0x42 -> pc held; misalign_exc=1 one cycle; bad_addr=0x42;
//     next trap_req with trap_vec=0x200 -> pc=0x200
//  T4 trap_req+mret_req+stall+br_taken same cycle, trap_vec=0x80, epc=0x30 -> pc=0x80;
//     mret_req alone -> pc=0x30
//  T5 wfi_req at pc=0x20 -> pc=0x24, sleeping=1, fetch_en=0; 5 idle cycles pc stays 0x24;
//     wake -> RUN, pc=0x24 then 0x28; repeat with trap_req -> pc=trap_vec, flush=1
//  T6 pc=0xFFFFFFFC sequential -> pc=0x0; PC_PERF_EN: 3 branches + 2 stalls -> redirect_cnt=3,
//     stall_cnt=2; reset mid-sleep -> RUN, pc=RESET_VEC, counters=0

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-address generator for the 3-stage RV32I pipeline: next-PC select, WFI sleep FSM,
// misaligned-target detection and flush pulse. Define PC_PERF_EN to add redirect/stall counters.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              IALIGN    = 4,
    parameter int              CNT_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret_req,
    input  logic [XLEN-1:0] epc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            wfi_req,
    input  logic            wake,
    output logic [XLEN-1:0] pc,
    output logic            fetch_en,
    output logic            flush,
    output logic            misalign_exc,
    output logic [XLEN-1:0] bad_addr,
`ifdef PC_PERF_EN
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic            sleeping
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(IALIGN);

    typedef enum logic {RUN, SLEEP} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] bad_addr_reg, bad_addr_next;
    logic            flush_reg, flush_next;
    logic            misalign_reg, misalign_next;
    logic            br_aligned;

    assign br_aligned = (br_target & ALIGN_MASK) == '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= RUN;
            pc_reg       <= RESET_VEC;
            bad_addr_reg <= '0;
            flush_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            bad_addr_reg <= bad_addr_next;
            flush_reg    <= flush_next;
            misalign_reg <= misalign_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        bad_addr_next = bad_addr_reg;
        flush_next    = 1'b0;
        misalign_next = 1'b0;
        case (state_reg)
            RUN: begin
                if (trap_req) begin
                    pc_next    = trap_vec & ~ALIGN_MASK;
                    flush_next = 1'b1;
                end else if (mret_req) begin
                    pc_next    = epc & ~ALIGN_MASK;
                    flush_next = 1'b1;
                end else if (stall) begin
                    pc_next = pc_reg;
                end else if (br_taken) begin
                    if (br_aligned) begin
                        pc_next    = br_target;
                        flush_next = 1'b1;
                    end else begin
                        // Hold PC; the CSR unit answers the exception with trap_req.
                        misalign_next = 1'b1;
                        bad_addr_next = br_target;
                    end
                end else if (wfi_req) begin
                    state_next = SLEEP;
                    pc_next    = pc_reg + PC_INC;
                end else begin
                    pc_next = pc_reg + PC_INC;
                end
            end
            SLEEP: begin
                if (trap_req) begin
                    state_next = RUN;
                    pc_next    = trap_vec & ~ALIGN_MASK;
                    flush_next = 1'b1;
                end else if (wake) begin
                    // PC already points at the instruction after the WFI.
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign pc           = pc_reg;
    assign fetch_en     = (state_reg == RUN);
    assign sleeping     = (state_reg == SLEEP);
    assign flush        = flush_reg;
    assign misalign_exc = misalign_reg;
    assign bad_addr     = bad_addr_reg;

`ifdef PC_PERF_EN
    logic             redirect_load, stall_cycle;
    logic [CNT_W-1:0] redirect_cnt_reg, stall_cnt_reg;

    assign redirect_load = (state_reg == RUN &&
                            (trap_req || mret_req || (!stall && br_taken && br_aligned))) ||
                           (state_reg == SLEEP && trap_req);
    assign stall_cycle   = (state_reg == RUN) && stall && !trap_req && !mret_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_cnt_reg <= '0;
            stall_cnt_reg    <= '0;
        end else begin
            if (redirect_load && redirect_cnt_reg != '1)
                redirect_cnt_reg <= redirect_cnt_reg + 1'b1;
            if (stall_cycle && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign redirect_cnt = redirect_cnt_reg;
    assign stall_cnt    = stall_cnt_reg;
`endif

endmodule
